// File: rtl/burst_tx_pkg.sv
// Shared definitions for the SP/CNT burst serial transmitter.
package burst_tx_pkg;

  localparam logic [11:0] BASE_ADDR_DEF = 12'hFDA;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  localparam int unsigned CTRL_EN    = 7;
  localparam int unsigned CTRL_FLUSH = 6;
  localparam int unsigned CTRL_IE    = 5;

  localparam int unsigned STAT_BUSY  = 7;
  localparam int unsigned STAT_EN    = 6;
  localparam int unsigned STAT_FULL  = 5;
  localparam int unsigned STAT_EMPTY = 4;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_GAP
  } tx_state_e;

endpackage

// File: rtl/burst_tx_fifo.sv
// Byte FIFO for the burst transmitter; updates on the falling edge of E_CLK.
module burst_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       E_CLK,
  input  logic       RESET_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == 3'(DEPTH));
  assign empty   = (count == 3'd0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(negedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(negedge E_CLK) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/burst_tx.sv
// SP/CNT burst serial transmitter: bus register window, byte FIFO, CNT generator.
module burst_tx
  import burst_tx_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  DIV_RESET  = 4'd3
) (
  input  logic        E_CLK,
  input  logic        RESET_n,
  input  logic        RW,
  input  logic        MUX,
  input  logic [15:0] A,
  inout  wire  [7:0]  D,
  inout  wire         CNT,
  inout  wire         SP,
  output logic        IRQ_n
);

  logic       sel, rd, wr, wr_data, wr_ctrl, rd_stat, flush;
  logic [7:0] rd_data, stat;
  logic       en, ie, ovf;
  logic [3:0] div;

  tx_state_e  state, state_n;
  logic [3:0] phase, phase_n, hdiv, hdiv_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shifter, shifter_n, cur_byte, cur_byte_n, last, last_n;
  logic       gap_half, gap_half_n;
  logic       cnt_low, cnt_low_n, sp_low, sp_low_n;
  logic       half_done, pop;

  logic [7:0] fifo_dout;
  logic [2:0] fifo_count;
  logic       fifo_full, fifo_empty;

  logic       unused_bits;
  assign unused_bits = ^{A[3:1], D[4]};

  assign sel     = (A[15:4] == BASE_ADDR);
  assign rd      = sel && RW;
  assign wr      = sel && !RW;
  assign wr_data = wr && (A[0] == REG_DATA);
  assign wr_ctrl = wr && (A[0] == REG_CTRL);
  assign rd_stat = rd && (A[0] == REG_CTRL);
  assign flush   = wr_ctrl && D[CTRL_FLUSH];

  always_comb begin
    stat             = '0;
    stat[STAT_BUSY]  = (state != ST_IDLE);
    stat[STAT_EN]    = en;
    stat[STAT_FULL]  = fifo_full;
    stat[STAT_EMPTY] = fifo_empty;
    stat[STAT_OVF]   = ovf;
    stat[2:0]        = fifo_count;
  end

  assign rd_data = (A[0] == REG_DATA) ? last : stat;
  assign D       = (rd && !MUX) ? rd_data : 'z;
  assign CNT     = cnt_low ? 1'b0 : 1'bz;
  assign SP      = sp_low ? 1'b0 : 1'bz;
  assign IRQ_n   = !(ie && fifo_empty && (state == ST_IDLE));

  burst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .E_CLK   (E_CLK),
    .RESET_n (RESET_n),
    .clr     (flush),
    .push    (wr_data),
    .pop     (pop),
    .din     (D),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(negedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      en  <= 1'b0;
      ie  <= 1'b0;
      div <= DIV_RESET;
      ovf <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en  <= D[CTRL_EN];
        ie  <= D[CTRL_IE];
        div <= D[3:0];
      end
      if (flush)                              ovf <= 1'b0;
      else if (wr_data && fifo_full && !pop)  ovf <= 1'b1;
      else if (rd_stat)                       ovf <= 1'b0;
    end
  end

  always_ff @(negedge E_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= ST_IDLE;
      phase    <= '0;
      hdiv     <= '0;
      bitcnt   <= '0;
      shifter  <= '0;
      cur_byte <= '0;
      last     <= '0;
      gap_half <= 1'b0;
      cnt_low  <= 1'b0;
      sp_low   <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      hdiv     <= hdiv_n;
      bitcnt   <= bitcnt_n;
      shifter  <= shifter_n;
      cur_byte <= cur_byte_n;
      last     <= last_n;
      gap_half <= gap_half_n;
      cnt_low  <= cnt_low_n;
      sp_low   <= sp_low_n;
    end
  end

  // hdiv latches DIV at each half-period boundary so a mid-byte change waits for the next one.
  assign half_done = (phase == hdiv);

  always_comb begin
    state_n    = state;
    phase_n    = phase + 4'd1;
    hdiv_n     = hdiv;
    bitcnt_n   = bitcnt;
    shifter_n  = shifter;
    cur_byte_n = cur_byte;
    last_n     = last;
    gap_half_n = gap_half;
    cnt_low_n  = cnt_low;
    sp_low_n   = sp_low;
    pop        = 1'b0;

    case (state)
      ST_IDLE: begin
        phase_n = '0;
        if (en && !fifo_empty) begin
          pop        = 1'b1;
          shifter_n  = fifo_dout;
          cur_byte_n = fifo_dout;
          bitcnt_n   = '0;
          sp_low_n   = !fifo_dout[7];
          cnt_low_n  = 1'b1;
          hdiv_n     = div;
          state_n    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (half_done) begin
          phase_n   = '0;
          hdiv_n    = div;
          cnt_low_n = 1'b0;
          state_n   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (half_done) begin
          phase_n = '0;
          hdiv_n  = div;
          if (bitcnt != 3'd7) begin
            bitcnt_n  = bitcnt + 3'd1;
            shifter_n = {shifter[6:0], 1'b0};
            sp_low_n  = !shifter[6];
            cnt_low_n = 1'b1;
            state_n   = ST_LOW;
          end else begin
            last_n     = cur_byte;
            sp_low_n   = 1'b0;
            gap_half_n = 1'b0;
            state_n    = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (half_done) begin
          phase_n = '0;
          hdiv_n  = div;
          if (gap_half) state_n    = ST_IDLE;
          else          gap_half_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (flush) begin
      pop       = 1'b0;
      state_n   = ST_IDLE;
      phase_n   = '0;
      cnt_low_n = 1'b0;
      sp_low_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_burst_tx.sv
// Directed bench for burst_tx: bus register access plus a CNT/SP receiver monitor.
module tb_burst_tx;

  localparam logic [15:0] A_DATA = 16'hFDA0;
  localparam logic [15:0] A_CTRL = 16'hFDA1;
  localparam logic [15:0] A_NONE = 16'h0000;

  logic        E_CLK = 1'b1;
  logic        RESET_n;
  logic        RW;
  logic        MUX;
  logic [15:0] A;
  logic [7:0]  d_drv;
  logic        d_oe;
  wire  [7:0]  D;
  wire         CNT;
  wire         SP;
  wire         IRQ_n;

  assign D = d_oe ? d_drv : 'z;
  pullup (CNT);
  pullup (SP);

  always #5 E_CLK = ~E_CLK;

  burst_tx #(
    .BASE_ADDR  (12'hFDA),
    .FIFO_DEPTH (4),
    .DIV_RESET  (4'd3)
  ) dut (
    .E_CLK   (E_CLK),
    .RESET_n (RESET_n),
    .RW      (RW),
    .MUX     (MUX),
    .A       (A),
    .D       (D),
    .CNT     (CNT),
    .SP      (SP),
    .IRQ_n   (IRQ_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receiver model: samples SP when CNT rises and measures CNT run lengths.
  logic [7:0] rx_q[$];
  int   rx_bits = 0;
  int   lo_min = 99, lo_max = 0, hi_min = 99, hi_max = 0, gap_min = 99;
  int   clr_req = 0;

  initial begin : monitor
    int   clr_ack, lo_run, hi_run;
    logic rx_any, cnt_prev, c;
    logic [7:0] rx_sh;
    clr_ack = 0; lo_run = 0; hi_run = 0; rx_any = 0; cnt_prev = 1'b1; rx_sh = '0;
    forever begin
      @(posedge E_CLK);
      if (clr_req != clr_ack) begin
        clr_ack = clr_req;
        rx_q.delete();
        rx_bits = 0; rx_any = 0; lo_run = 0; hi_run = 0;
        lo_min = 99; lo_max = 0; hi_min = 99; hi_max = 0; gap_min = 99;
      end
      c = (CNT !== 1'b0);
      if (!c) begin
        if (cnt_prev) begin
          if (rx_bits % 8 != 0) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
          end else if (rx_any && hi_run < gap_min) begin
            gap_min = hi_run;
          end
          lo_run = 0;
        end
        lo_run++;
      end else begin
        if (!cnt_prev) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
          rx_sh = {rx_sh[6:0], (SP !== 1'b0)};
          rx_bits++;
          rx_any = 1'b1;
          if (rx_bits % 8 == 0) rx_q.push_back(rx_sh);
          hi_run = 0;
        end
        hi_run++;
      end
      cnt_prev = c;
    end
  end

  task automatic cycle();
    @(negedge E_CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
    A = addr; RW = 1'b0; d_drv = data; d_oe = 1'b1;
    cycle();
    d_oe = 1'b0; RW = 1'b1; A = A_NONE;
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [7:0] data);
    A = addr; RW = 1'b1; MUX = 1'b0;
    @(posedge E_CLK);
    data = D;
    cycle();
    MUX = 1'b1; A = A_NONE;
  endtask

  initial begin : main
    logic [7:0] rv;
    logic       prev, found;
    int         n;
    RESET_n = 1'b0; RW = 1'b1; MUX = 1'b1; A = A_NONE; d_drv = '0; d_oe = 1'b0;
    #12 RESET_n = 1'b1;
    cycle();

    // Reset state
    check("rst_cnt", 32'(CNT), 32'd1);
    check("rst_sp", 32'(SP), 32'd1);
    check("rst_irq", 32'(IRQ_n), 32'd1);
    bus_rd(A_CTRL, rv);
    check("rst_stat", 32'(rv), 32'h10);

    // DIV=0, one byte
    clr_req++;
    bus_wr(A_CTRL, 8'h80);
    bus_wr(A_DATA, 8'hA5);
    repeat (30) cycle();
    check("a5_nbytes", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("a5_byte", 32'(rx_q[0]), 32'hA5);
    check("a5_lo_min", 32'(lo_min), 32'd1);
    check("a5_lo_max", 32'(lo_max), 32'd1);
    check("a5_hi_min", 32'(hi_min), 32'd1);
    check("a5_hi_max", 32'(hi_max), 32'd1);
    bus_rd(A_DATA, rv);
    check("a5_last", 32'(rv), 32'hA5);
    bus_rd(A_CTRL, rv);
    check("a5_stat", 32'(rv), 32'h50);

    // H=4, five back-to-back writes; first pop coincides with the second write
    clr_req++;
    bus_wr(A_CTRL, 8'h83);
    for (int i = 1; i <= 5; i++) bus_wr(A_DATA, 8'(i));
    bus_rd(A_CTRL, rv);
    check("b5_stat", 32'(rv), 32'hE4);
    for (int i = 0; i < 1000 && rx_q.size() < 5; i++) cycle();
    repeat (20) cycle();
    check("b5_nbytes", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check("b5_byte", 32'(rx_q[i]), 32'(i + 1));
    check("b5_lo_min", 32'(lo_min), 32'd4);
    check("b5_lo_max", 32'(lo_max), 32'd4);
    check("b5_hi_min", 32'(hi_min), 32'd4);
    check("b5_hi_max", 32'(hi_max), 32'd4);
    check("b5_gap_ge_3h", 32'(gap_min >= 12), 32'd1);
    bus_rd(A_DATA, rv);
    check("b5_last", 32'(rv), 32'h05);

    // EN=0: fill, overflow, OVF cleared by the STAT read
    bus_wr(A_CTRL, 8'h40);
    bus_wr(A_DATA, 8'h11);
    bus_wr(A_DATA, 8'h22);
    bus_wr(A_DATA, 8'h33);
    bus_wr(A_DATA, 8'h44);
    bus_rd(A_CTRL, rv);
    check("full_stat", 32'(rv), 32'h24);
    bus_wr(A_DATA, 8'h55);
    bus_rd(A_CTRL, rv);
    check("ovf_stat", 32'(rv), 32'h2C);
    bus_rd(A_CTRL, rv);
    check("ovf_clr_stat", 32'(rv), 32'h24);

    // Flush at the start of bit 3 of 8'hFF
    bus_wr(A_CTRL, 8'h43);
    clr_req++;
    bus_wr(A_DATA, 8'hFF);
    bus_wr(A_CTRL, 8'h83);
    found = 1'b0;
    prev = (CNT !== 1'b0);
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (prev && CNT === 1'b0 && rx_bits >= 3) begin
        found = 1'b1;
        break;
      end
      prev = (CNT !== 1'b0);
    end
    check("fl_found_bit3", 32'(found), 32'd1);
    bus_wr(A_CTRL, 8'hC0);
    check("fl_cnt", 32'(CNT), 32'd1);
    check("fl_sp", 32'(SP), 32'd1);
    bus_rd(A_CTRL, rv);
    check("fl_stat", 32'(rv), 32'h50);
    bus_rd(A_DATA, rv);
    check("fl_last", 32'(rv), 32'h05);

    // Empty interrupt across a byte
    bus_wr(A_CTRL, 8'hA0);
    check("irq_idle", 32'(IRQ_n), 32'd0);
    clr_req++;
    bus_wr(A_DATA, 8'h3C);
    check("irq_busy", 32'(IRQ_n), 32'd1);
    n = 0;
    while (IRQ_n === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    check("irq_back", 32'(IRQ_n), 32'd0);
    check("irq_cycles", 32'(n), 32'd19);
    check("irq_nbytes", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("irq_byte", 32'(rx_q[0]), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
